// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path (transmitter and detectors).
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } seq_state_e;

    localparam logic [3:0] DEF_PATTERN = 4'b1100;

endpackage

// File: rtl/seq_tx_piso_shift.sv
// Parallel-load, shift-left register; the MSB is the serial output bit.
module piso_shift #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first rep_count times
// with gap_len idle-0 cycles between frames.
module seq_tx
    import seq_pkg::*;
#(
    parameter int unsigned         PAT_W   = 4,
    parameter int unsigned         CNT_W   = 8,
    parameter int unsigned         GAP_W   = 4,
    parameter logic [PAT_W-1:0]    PAT_DEF = PAT_W'(DEF_PATTERN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x,
    output logic             busy,
    output logic             frame_end,
    output logic             done
);

    localparam int unsigned BW = $clog2(PAT_W);
    localparam logic [BW-1:0] LAST_IDX = BW'(PAT_W - 1);

    seq_state_e       state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] load_val;
    logic             load, shift, sr_msb;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        reps_d    = reps_q;
        gap_cnt_d = gap_cnt_q;
        gap_len_d = gap_len_q;
        pat_d     = pat_q;
        load      = 1'b0;
        shift     = 1'b0;
        load_val  = pat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d     = use_def ? PAT_DEF : pattern;
                    gap_len_d = gap_len;
                    reps_d    = rep_count;
                    if (rep_count == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d  = SEND;
                        load     = 1'b1;
                        load_val = pat_d;
                        bit_d    = LAST_IDX;
                    end
                end
            end
            SEND: begin
                if (bit_q == '0) begin
                    // reps_q==1 is tested before decrementing so a full-scale count never wraps
                    reps_d = reps_q - CNT_W'(1);
                    if (reps_q == CNT_W'(1)) begin
                        state_d = FIN;
                    end else if (gap_len_q == '0) begin
                        load  = 1'b1;
                        bit_d = LAST_IDX;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q;
                    end
                end else begin
                    shift = 1'b1;
                    bit_d = bit_q - BW'(1);
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = SEND;
                    load    = 1'b1;
                    bit_d   = LAST_IDX;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            reps_q    <= '0;
            gap_cnt_q <= '0;
            gap_len_q <= '0;
            pat_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            reps_q    <= reps_d;
            gap_cnt_q <= gap_cnt_d;
            gap_len_q <= gap_len_d;
            pat_q     <= pat_d;
        end
    end

    piso_shift #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .rst_n (reset),
        .load  (load),
        .shift (shift),
        .din   (load_val),
        .msb   (sr_msb)
    );

    assign x         = (state_q == SEND) && sr_msb;
    assign busy      = (state_q == SEND) || (state_q == GAP);
    assign frame_end = (state_q == SEND) && (bit_q == '0);
    assign done      = (state_q == FIN);

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: waveform vectors per cycle plus a loopback 1100 detector.
module tb_seq_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       use_def;
    logic [3:0] pattern;
    logic [7:0] rep_count;
    logic [3:0] gap_len;
    logic       x, busy, frame_end, done;

    int checks   = 0;
    int failures = 0;

    logic [2:0] hist = '0;
    logic       det;

    seq_tx #(
        .PAT_W   (4),
        .CNT_W   (8),
        .GAP_W   (4),
        .PAT_DEF (4'b1100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .use_def   (use_def),
        .pattern   (pattern),
        .rep_count (rep_count),
        .gap_len   (gap_len),
        .x         (x),
        .busy      (busy),
        .frame_end (frame_end),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference 1100 detector on the serial line: flags the cycle carrying the last bit.
    always_ff @(posedge clk) hist <= {hist[1:0], x};
    assign det = ({hist, x} == 4'b1100);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ex, input logic eb,
                           input logic ef, input logic ed);
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".frame_end"}, 32'(frame_end), 32'(ef));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic ud, input logic [3:0] p, input logic [7:0] rc,
                          input logic [3:0] gl);
        use_def   = ud;
        pattern   = p;
        rep_count = rc;
        gap_len   = gl;
        start     = 1'b1;
    endtask

    task automatic release_reset();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] xv;
        logic [15:0] fv;
        logic [11:0] xb;
        logic [11:0] fb;
        logic [9:0]  x5;
        logic [9:0]  f5;
        int n, bc, fes;
        logic seen;

        reset = 1'b0; start = 1'b0; use_def = 1'b0;
        pattern = '0; rep_count = '0; gap_len = '0;
        #2;
        chk_out("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        reset = 1'b1;
        step();
        chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single default frame
        launch(1'b1, 4'b0000, 8'd1, 4'd0);
        xv = 16'b1100_0000_0000_0000;
        for (int c = 1; c <= 4; c++) begin
            step(); start = 1'b0;
            chk_out("single", xv[16-c], 1'b1, (c == 4), 1'b0);
        end
        step(); chk_out("single_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step(); chk_out("single_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Three frames of 1010 with a two-cycle gap
        launch(1'b0, 4'b1010, 8'd3, 4'd2);
        xv = 16'b1010_00_1010_00_1010;
        fv = 16'b0001_00_0001_00_0001;
        for (int c = 1; c <= 16; c++) begin
            step(); start = 1'b0;
            chk_out("gap2", xv[16-c], 1'b1, fv[16-c], 1'b0);
        end
        step(); chk_out("gap2_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // Back-to-back frames
        launch(1'b0, 4'b1010, 8'd3, 4'd0);
        xb = 12'b1010_1010_1010;
        fb = 12'b0001_0001_0001;
        for (int c = 1; c <= 12; c++) begin
            step(); start = 1'b0;
            chk_out("b2b", xb[12-c], 1'b1, fb[12-c], 1'b0);
        end
        step(); chk_out("b2b_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // Zero repeats
        launch(1'b1, 4'b0000, 8'd0, 4'd3);
        step(); start = 1'b0;
        chk_out("zero_rep", 1'b0, 1'b0, 1'b0, 1'b1);
        step(); chk_out("zero_rep_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Input stability, start during busy and during done
        launch(1'b1, 4'b0000, 8'd1, 4'd0);
        x5 = 10'b1100_00_0110;
        f5 = 10'b0001_00_0001;
        for (int c = 1; c <= 10; c++) begin
            step();
            case (c)
                1: begin start = 1'b0; pattern = 4'b0110; use_def = 1'b0; rep_count = 8'd2; end
                2: start = 1'b1;
                3: start = 1'b0;
                5: begin start = 1'b1; rep_count = 8'd1; end
                7: start = 1'b0;
                default: ;
            endcase
            chk_out("stable", x5[10-c], (c != 5 && c != 6), f5[10-c], (c == 5));
        end
        step(); chk_out("stable_done", 1'b0, 1'b0, 1'b0, 1'b1);
        step(); chk_out("stable_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Loopback against the 1100 detector
        launch(1'b1, 4'b0000, 8'd5, 4'd1);
        bc = 0;
        for (int c = 1; c <= 24; c++) begin
            step(); start = 1'b0;
            if (busy) bc++;
            chk("loop.det", 32'(det), 32'((c % 5) == 4));
            chk("loop.fe", 32'(frame_end), 32'((c % 5) == 4));
        end
        step();
        chk("loop.done", 32'(done), 32'd1);
        chk("loop.det_done", 32'(det), 32'd0);
        chk("loop.busy_cycles", 32'(bc), 32'd24);
        step();

        // Full-scale repeat count and gap length
        launch(1'b1, 4'b0000, 8'd255, 4'd15);
        n = 0; bc = 0; fes = 0; seen = 1'b0;
        while (!seen && n < 6000) begin
            step(); start = 1'b0;
            n++;
            if (busy) bc++;
            if (frame_end) fes++;
            if (done) seen = 1'b1;
        end
        chk("max.done_seen", 32'(seen), 32'd1);
        chk("max.done_cycle", 32'(n), 32'd4831);
        chk("max.busy_cycles", 32'(bc), 32'd4830);
        chk("max.frames", 32'(fes), 32'd255);
        step();

        // Asynchronous reset mid-frame while x and busy are high
        launch(1'b0, 4'b1010, 8'd3, 4'd2);
        for (int c = 1; c <= 3; c++) begin
            step(); start = 1'b0;
        end
        chk_out("pre_reset_bit", 1'b1, 1'b1, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 chk_out("async_reset_bit", 1'b0, 1'b0, 1'b0, 1'b0);
        release_reset();

        // Asynchronous reset during a frame_end cycle
        launch(1'b1, 4'b0000, 8'd2, 4'd0);
        for (int c = 1; c <= 4; c++) begin
            step(); start = 1'b0;
        end
        chk_out("pre_reset_fe", 1'b0, 1'b1, 1'b1, 1'b0);
        #1 reset = 1'b0;
        #1 chk_out("async_reset_fe", 1'b0, 1'b0, 1'b0, 1'b0);
        release_reset();

        // Asynchronous reset during the done cycle
        launch(1'b1, 4'b0000, 8'd0, 4'd0);
        step(); start = 1'b0;
        chk_out("pre_reset_done", 1'b0, 1'b0, 1'b0, 1'b1);
        #1 reset = 1'b0;
        #1 chk_out("async_reset_done", 1'b0, 1'b0, 1'b0, 1'b0);
        release_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
